// File: rtl/decode_elastic_preg_if.sv
// Handshake and payload bundle between decode, the elastic decode register and execute.
// slave: the register itself; master: the decode/execute side driving it.
interface decode_elastic_preg_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 24,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  i_valid;
    logic                  o_ready;
    logic [CTRL_W-1:0]     i_ctrl;
    logic                  i_reg_we;
    logic                  i_load_instr;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic [ADDR_WIDTH-1:0] i_pc_plus4;
    logic [DATA_WIDTH-1:0] i_imm_ext;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic [REG_ADDR_W-1:0] i_rs1_addr;
    logic [REG_ADDR_W-1:0] i_rs2_addr;
    logic [REG_ADDR_W-1:0] i_rd_addr;

    logic                  o_valid;
    logic                  i_ready;
    logic [CTRL_W-1:0]     o_ctrl;
    logic                  o_reg_we;
    logic                  o_load_instr;
    logic [ADDR_WIDTH-1:0] o_pc;
    logic [ADDR_WIDTH-1:0] o_pc_plus4;
    logic [DATA_WIDTH-1:0] o_imm_ext;
    logic [DATA_WIDTH-1:0] o_rs1_data;
    logic [DATA_WIDTH-1:0] o_rs2_data;
    logic [REG_ADDR_W-1:0] o_rs1_addr;
    logic [REG_ADDR_W-1:0] o_rs2_addr;
    logic [REG_ADDR_W-1:0] o_rd_addr;
    logic [CNT_W-1:0]      o_count;
    logic                  o_load_use_hazard;

    modport slave (
        input  i_valid, i_ctrl, i_reg_we, i_load_instr, i_pc, i_pc_plus4, i_imm_ext,
               i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr, i_rd_addr, i_ready,
        output o_ready, o_valid, o_ctrl, o_reg_we, o_load_instr, o_pc, o_pc_plus4,
               o_imm_ext, o_rs1_data, o_rs2_data, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_count, o_load_use_hazard
    );

    modport master (
        output i_valid, i_ctrl, i_reg_we, i_load_instr, i_pc, i_pc_plus4, i_imm_ext,
               i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr, i_rd_addr, i_ready,
        input  o_ready, o_valid, o_ctrl, o_reg_we, o_load_instr, o_pc, o_pc_plus4,
               o_imm_ext, o_rs1_data, o_rs2_data, o_rs1_addr, o_rs2_addr, o_rd_addr,
               o_count, o_load_use_hazard
    );
endinterface

// File: rtl/decode_elastic_preg.sv
// Elastic decode-to-execute register: DEPTH-entry circular queue with flush and x0 write gating.
// Latency: entry pushed at edge N is presented at the head right after edge N; 1 entry/cycle.
// Backpressure: o_ready = not full, from registered state only; macro DECODE_PREG_HAZARD_EN adds load-use hazard flag.
module decode_elastic_preg #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 24,
    parameter int DEPTH      = 2
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_flush,
    decode_elastic_preg_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CTRL_W-1:0]     ctrl;
        logic                  reg_we;
        logic                  load_instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wrptr_q, wrptr_d;
    logic [PTR_W-1:0]  rdptr_q, rdptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic   full, empty, push, pop, wr_en;
    entry_t wr_entry, head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.i_valid & ~full;
    assign pop   = ~empty & bus.i_ready;

    always_comb begin
        wr_entry            = '0;
        wr_entry.ctrl       = bus.i_ctrl;
        wr_entry.reg_we     = bus.i_reg_we & (bus.i_rd_addr != '0);
        wr_entry.load_instr = bus.i_load_instr;
        wr_entry.pc         = bus.i_pc;
        wr_entry.pc_plus4   = bus.i_pc_plus4;
        wr_entry.imm_ext    = bus.i_imm_ext;
        wr_entry.rs1_data   = bus.i_rs1_data;
        wr_entry.rs2_data   = bus.i_rs2_data;
        wr_entry.rs1_addr   = bus.i_rs1_addr;
        wr_entry.rs2_addr   = bus.i_rs2_addr;
        wr_entry.rd_addr    = bus.i_rd_addr;
    end

    // Flush wins over any push or pop in the same cycle.
    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (i_flush) begin
            wrptr_d = '0;
            rdptr_d = '0;
            count_d = '0;
        end else begin
            wr_en = push;
            if (push) begin
                wrptr_d = wrptr_q + PTR_W'(1);
            end
            if (pop) begin
                rdptr_d = rdptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: every output is masked while the queue is empty.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_arst) begin
            mem_q[wrptr_q] <= wr_entry;
        end
    end

    assign head = empty ? '0 : mem_q[rdptr_q];

    assign bus.o_ready      = ~full;
    assign bus.o_valid      = ~empty;
    assign bus.o_count      = count_q;
    assign bus.o_ctrl       = head.ctrl;
    assign bus.o_reg_we     = head.reg_we;
    assign bus.o_load_instr = head.load_instr;
    assign bus.o_pc         = head.pc;
    assign bus.o_pc_plus4   = head.pc_plus4;
    assign bus.o_imm_ext    = head.imm_ext;
    assign bus.o_rs1_data   = head.rs1_data;
    assign bus.o_rs2_data   = head.rs2_data;
    assign bus.o_rs1_addr   = head.rs1_addr;
    assign bus.o_rs2_addr   = head.rs2_addr;
    assign bus.o_rd_addr    = head.rd_addr;

`ifdef DECODE_PREG_HAZARD_EN
    logic             hazard;
    logic [PTR_W-1:0] slot_dist;

    // A physical slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        hazard    = 1'b0;
        slot_dist = '0;
        for (int j = 0; j < DEPTH; j++) begin
            slot_dist = PTR_W'(j) - rdptr_q;
            if (({1'b0, slot_dist} < count_q) && mem_q[j].load_instr && mem_q[j].reg_we &&
                ((mem_q[j].rd_addr == bus.i_rs1_addr) || (mem_q[j].rd_addr == bus.i_rs2_addr))) begin
                hazard = 1'b1;
            end
        end
    end

    assign bus.o_load_use_hazard = bus.i_valid & hazard;
`else
    assign bus.o_load_use_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_decode_elastic_preg.sv
// Directed, table-driven bench for decode_elastic_preg at DEPTH = 2.
module tb_decode_elastic_preg;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int CW = 24;
    localparam int DEPTH = 2;
    localparam logic [63:0] IMM_K = 64'hFFFF_0000_0000_0000;
`ifdef DECODE_PREG_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst;
    logic flush;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    decode_elastic_preg_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_W(RW),
                             .CTRL_W(CW), .DEPTH(DEPTH)) bus ();

    decode_elastic_preg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_ADDR_W(RW),
                          .CTRL_W(CW), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_arst  (arst),
        .i_flush (flush),
        .bus     (bus.slave)
    );

    typedef struct {
        bit          flush;
        bit          valid;
        bit          ready;
        bit          load;
        bit          we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] pc;
        bit          e_valid;
        bit          e_ready;
        int          e_count;
        logic [63:0] e_pc;
        bit          e_we;
        bit          e_haz;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit fl, bit v, bit r, bit ld, bit we, int rd, int rs1, int rs2,
                                logic [63:0] pc, bit ev, bit er, int ec, logic [63:0] epc,
                                bit ewe, bit ehz);
        vec_t t;
        t.flush = fl; t.valid = v; t.ready = r; t.load = ld; t.we = we;
        t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.pc = pc;
        t.e_valid = ev; t.e_ready = er; t.e_count = ec; t.e_pc = epc;
        t.e_we = ewe; t.e_haz = ehz;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit fl, input bit v, input bit r, input bit ld, input bit we,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [63:0] pc);
        flush            = fl;
        bus.i_valid      = v;
        bus.i_ready      = r;
        bus.i_load_instr = ld;
        bus.i_reg_we     = we;
        bus.i_rd_addr    = rd;
        bus.i_rs1_addr   = rs1;
        bus.i_rs2_addr   = rs2;
        bus.i_pc         = pc;
        bus.i_pc_plus4   = pc + 64'd4;
        bus.i_imm_ext    = pc ^ IMM_K;
        bus.i_rs1_data   = pc;
        bus.i_rs2_data   = ~pc;
        bus.i_ctrl       = pc[23:0];
    endtask

    task automatic check_state(input string tag, input bit ev, input bit er, input int ec,
                               input logic [63:0] epc, input bit ewe, input bit ehz);
        chk({tag, ".valid"}, 64'(bus.o_valid), 64'(ev));
        chk({tag, ".ready"}, 64'(bus.o_ready), 64'(er));
        chk({tag, ".count"}, 64'(bus.o_count), 64'(ec));
        chk({tag, ".pc"}, bus.o_pc, epc);
        chk({tag, ".pc4"}, bus.o_pc_plus4, ev ? epc + 64'd4 : 64'd0);
        chk({tag, ".imm"}, bus.o_imm_ext, ev ? (epc ^ IMM_K) : 64'd0);
        chk({tag, ".reg_we"}, 64'(bus.o_reg_we), 64'(ewe));
        chk({tag, ".hazard"}, 64'(bus.o_load_use_hazard), 64'(ehz));
    endtask

    initial begin
        arst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("reset", 0, 1, 0, 64'd0, 0, 0);
        arst = 1'b0;

        // Fill to full, blocked push during a pop, drain, then empty with i_ready high.
        vecs.push_back(mk(0,1,0,0,1,1,0,0,64'h100, 0,1,0,64'h0,0,0));
        vecs.push_back(mk(0,1,0,0,1,2,0,0,64'h104, 1,1,1,64'h100,1,0));
        vecs.push_back(mk(0,1,1,0,1,3,0,0,64'h108, 1,0,2,64'h100,1,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,0,64'h0,   1,1,1,64'h104,1,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,0,64'h0,   0,1,0,64'h0,0,0));
        // x0 write gating.
        vecs.push_back(mk(0,1,0,0,1,0,0,0,64'h110, 0,1,0,64'h0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0,0,64'h0,   1,1,1,64'h110,0,0));
        vecs.push_back(mk(0,1,0,0,1,5,0,0,64'h114, 0,1,0,64'h0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,64'h0,   1,1,1,64'h114,1,0));
        // Simultaneous push/pop at count 1 across pointer wrap.
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0,1,1,0,1,5,0,0,64'h200 + 64'(4*k), 1,1,1,
                              (k == 0) ? 64'h114 : 64'h200 + 64'(4*(k-1)),1,0));
        end
        // Queue a load rd=7 behind a non-load rd=5, then probe hazards while full.
        vecs.push_back(mk(0,1,0,1,1,7,0,0,64'h300, 1,1,1,64'h21C,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,7,64'h400, 1,0,2,64'h21C,1,HZ));
        vecs.push_back(mk(0,1,0,0,0,0,7,0,64'h404, 1,0,2,64'h21C,1,HZ));
        vecs.push_back(mk(0,1,0,0,0,0,5,0,64'h408, 1,0,2,64'h21C,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,7,64'h0,   1,0,2,64'h21C,1,0));
        // Flush with a simultaneous push and pop.
        vecs.push_back(mk(1,1,1,0,1,1,0,0,64'h500, 1,0,2,64'h21C,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,64'h0,   0,1,0,64'h0,0,0));
        // Load to x0 never raises a hazard.
        vecs.push_back(mk(0,1,0,1,1,0,0,0,64'h600, 0,1,0,64'h0,0,0));
        vecs.push_back(mk(0,1,0,0,0,3,0,0,64'h604, 1,1,1,64'h600,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,64'h0,   1,0,2,64'h600,0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].load, vecs[i].we,
                  vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].pc);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                        vecs[i].e_count, vecs[i].e_pc, vecs[i].e_we, vecs[i].e_haz);
        end

        // Reset while full, with a push and pop offered in the same cycle.
        @(negedge clk);
        arst = 1'b1;
        drive(0, 1, 1, 0, 1, 5'd4, 0, 0, 64'h680);
        @(negedge clk);
        arst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        #1;
        check_state("midreset", 0, 1, 0, 64'd0, 0, 0);

        // First push after reset lands at the head with all fields intact.
        @(negedge clk);
        drive(0, 1, 0, 1, 1, 5'd9, 5'd3, 5'd4, 64'h700);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        #1;
        check_state("postreset", 1, 1, 1, 64'h700, 1, 0);
        chk("postreset.rd",   64'(bus.o_rd_addr), 64'd9);
        chk("postreset.rs1",  64'(bus.o_rs1_addr), 64'd3);
        chk("postreset.rs2",  64'(bus.o_rs2_addr), 64'd4);
        chk("postreset.load", 64'(bus.o_load_instr), 64'd1);
        chk("postreset.ctrl", 64'(bus.o_ctrl), 64'h700);
        chk("postreset.rs2d", bus.o_rs2_data, ~64'h700);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/decode_elastic_preg.md
# decode_elastic_preg

Elastic, parametrised decode-to-execute pipeline register that replaces the fixed single-entry decode register. It buffers up to DEPTH decoded instructions in a circular queue and moves them with a valid/ready handshake on both sides. It supports synchronous flush and gates register writes to x0. It can also flag load-use hazards between the instruction being decoded and loads still queued.

## Interface
Parameters:
- ADDR_WIDTH, 64, PC width.
- DATA_WIDTH, 64, operand/immediate width.
- REG_ADDR_W, 5, register address width.
- CTRL_W, 24, packed control bundle width (result_src, alu_control, mem_we, alu_src, branch, jump, etc.), opaque to this block.
- DEPTH, 2, number of entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_arst  in  1  reset; **synchronous, active-high** (name kept from codebase).
- i_flush  in  1  synchronous flush of all entries.
- i_valid  in  1  upstream (decode) holds a valid instruction.
- o_ready  out  1  block can accept an entry this cycle.
- i_ctrl  in  CTRL_W  packed control bundle.
- i_reg_we  in  1  register write enable from control unit.
- i_load_instr  in  1  instruction is a load.
- i_pc, i_pc_plus4  in  ADDR_WIDTH  PC and PC+4.
- i_imm_ext, i_rs1_data, i_rs2_data  in  DATA_WIDTH  immediate and operands.
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  REG_ADDR_W  register addresses.
- o_valid  out  1  head entry valid.
- i_ready  in  1  execute stage accepts head (inverse of execute stall).
- o_ctrl, o_reg_we, o_load_instr, o_pc, o_pc_plus4, o_imm_ext, o_rs1_data, o_rs2_data, o_rs1_addr, o_rs2_addr, o_rd_addr  out  (matching widths)  head entry fields.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_load_use_hazard  out  1  load-use hazard on current input (see Configuration).

## Operation
- Push when i_valid & o_ready; pop when o_valid & i_ready.
- Storage is a circular buffer with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- o_ready = (count != DEPTH). It is registered-state only, with no combinational path from i_ready.
- o_valid = (count != 0).
- Stored reg_we = i_reg_we & (i_rd_addr != 0).
- Head fields are presented from storage. All payload outputs are driven to 0 while o_valid = 0.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal for 1 ≤ count ≤ DEPTH-1.
- Full: a push is blocked by o_ready = 0. A pop in the same cycle still completes, and the push is not taken.
- Empty: no pop occurs; i_ready is ignored.
- Flush (i_flush = 1): at the next edge count, wrptr and rdptr are set to 0. Any push or pop in that cycle is discarded, and flush has priority over both.
- Reset (i_arst = 1): same as flush. Storage contents need not clear, because outputs are masked by o_valid.
- Reset or flush mid-operation drops all entries, with no partial state left.

## Timing
- Latency: an entry pushed at edge N is on the outputs with o_valid = 1 from after edge N.
- Throughput: one entry per cycle in steady state.
- o_load_use_hazard is combinational from the inputs and registered state, and is valid in the same cycle.
- Reset values: o_valid 0, o_ready 1, o_count 0, all payload outputs 0, o_load_use_hazard 0.

## Configuration
Macro **DECODE_PREG_HAZARD_EN**.
- Defined: o_load_use_hazard = i_valid & OR over valid entries e of (load_instr_e & reg_we_e & ((rd_e == i_rs1_addr) | (rd_e == i_rs2_addr))).
  - The hazard is advisory: the block still accepts a push, and upstream is responsible for stalling.
- Not defined: o_load_use_hazard is tied to 0, and no comparators are built.

## Test plan
- Reset, then idle with i_arst = 1 for 2 cycles → o_valid 0, o_ready 1, o_count 0, o_pc 0.
- DEPTH = 2, push pc 0x100 then 0x104 with i_ready = 0 → o_count 2, o_ready 0. A third push of 0x108 is not accepted. Raise i_ready → pops 0x100 then 0x104, in order.
- Push rd = 0 with i_reg_we = 1 → o_reg_we 0. Push rd = 5 with i_reg_we = 1 → o_reg_we 1.
- Count = 1, simultaneous push 0x200 and pop → o_count stays 1, head becomes 0x200. Repeat over 8 cycles to exercise pointer wrap.
- Count = 2, assert i_flush together with i_valid → next cycle o_count 0 and o_valid 0. The flushed-cycle push is absent.
- With DECODE_PREG_HAZARD_EN defined, queued load with rd = 7, then input i_rs2_addr = 7 with i_valid = 1 → o_load_use_hazard 1. Rd = 0 load, or a non-load, → 0. With the macro undefined → always 0.
